lu_serial_ctrl: RTL and testbench
=================================

// Module: lu_serial_ctrl
// PURPOSE
//   Bit-serial sequencer for the existing 1-bit logic unit (NAND/AND/NOR/OR).
//   Accepts two WIDTH-bit operands and a 2-bit opcode, then feeds one bit pair
//   per cycle to the unit, LSB first. Collects the unit's 1-bit output into a
//   WIDTH-bit result. Sits between the register-level datapath and one shared
//   1-bit logic unit instance, which is wired outside this block.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk              in   1      single clock; all state updates on rising edge
//   reset            in   1      synchronous, active-high reset
//   start            in   1      request; sampled only in IDLE
//   op               in   2      op[1]=select_group, op[0]=select_op
//                                (00 NAND, 01 AND, 10 NOR, 11 OR)
//   a_in             in   WIDTH  operand A, latched on accepted start
//   b_in             in   WIDTH  operand B, latched on accepted start
//   lu_a             out  1      bit of A to the logic unit
//   lu_b             out  1      bit of B to the logic unit
//   lu_select_op     out  1      to the unit's select_op
//   lu_select_group  out  1      to the unit's select_group
//   lu_s             in   1      logic unit output (combinational from lu_*)
//   busy             out  1      high in RUN
//   done             out  1      one-cycle pulse when result is complete
//   result           out  WIDTH  assembled result; held until next accepted start
//   zero             out  1      result==0; valid and held with result
// BEHAVIOUR
//   Clock and reset: one clock (clk). Reset is synchronous, active-high (reset).
//   Reset values: state=IDLE, busy=0, done=0, result=0, zero=0.
//     lu_a=lu_b=lu_select_op=lu_select_group=0.
//     Internal shift registers, op latch and bit counter are also cleared.
//   FSM:
//     IDLE -> RUN on start=1. Same edge latches a_in, b_in, op and clears
//       the counter. result is cleared to 0 and zero to 0.
//     RUN: lu_a=a_sh[0], lu_b=b_sh[0], lu_select_*=op latch (all from registers).
//       Each edge: result <= {lu_s, result[WIDTH-1:1]}; a_sh,b_sh >>= 1; cnt++.
//       After WIDTH samples -> DONE.
//     DONE: done=1 for exactly one cycle; zero <= (result==0). Then -> IDLE.
//   Latency: start sampled at edge E0. RUN occupies cycles 1..WIDTH. done is
//     high in cycle WIDTH+1. Back-to-back: the next start is accepted at
//     edge E0+WIDTH+2.
//   Start while RUN or DONE is ignored. Operand and opcode changes after
//     acceptance have no effect.
//   Outside RUN, lu_a and lu_b are driven 0. lu_select_* keep the last op.
//   Reset asserted mid-RUN: next edge forces the reset values. No done pulse;
//     the partial result is discarded.
//   Reset and start high on the same edge: reset wins; start is not accepted.
//   Counter width $clog2(WIDTH+1). No wrap-around is possible within RUN.
// TESTING (WIDTH=8; bench instantiates the real 1-bit logic unit on lu_*)
//   1. a=F0 b=CC op=01, start 1 cycle -> busy cycles 1..8, done cycle 9,
//      result=C0, zero=0.
//   2. Same operands, op=11 / 00 / 10 -> result FC / 3F / 03.
//      lu_select_group/op match op during RUN.
//   3. a=0F b=F0 op=01 -> result=00, zero=1. Then op=10 with a=b=FF
//      -> result=00, zero=1.
//   4. start held high continuously with a=AA b=55 op=11 -> result=FF.
//      Starts are accepted every 10 cycles. Changes to a_in mid-RUN are ignored.
//   5. reset pulsed in cycle 4 of RUN -> next cycle busy=0, result=0,
//      no done pulse. A fresh start then completes correctly.
//   6. Self-check on every cycle: lu_a/lu_b equal the latched operand bit
//      for the current count, and done is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/lu_serial_ctrl.sv
// lu_serial_ctrl
//   Bit-serial sequencer for a shared 1-bit logic unit (NAND/AND/NOR/OR).
//   An accepted start latches two WIDTH-bit operands and a 2-bit opcode.
//   The block then presents one operand bit pair per cycle to the unit,
//   LSB first, and shifts the unit's 1-bit answer into a WIDTH-bit result.
//   The logic unit instance itself lives outside this block.
//
// Ports
//   clk              in   1      clock, rising edge
//   reset            in   1      synchronous, active-high
//   start            in   1      request, honoured only while idle
//   op               in   2      {select_group, select_op}: 00 NAND 01 AND 10 NOR 11 OR
//   a_in, b_in       in   WIDTH  operands, latched on an accepted start
//   lu_a, lu_b       out  1      current operand bits to the logic unit (0 when not running)
//   lu_select_op     out  1      latched op[0]
//   lu_select_group  out  1      latched op[1]
//   lu_s             in   1      logic unit output
//   busy             out  1      high while bits are being streamed
//   done             out  1      single-cycle pulse once the result is complete
//   result           out  WIDTH  assembled result, held until the next accepted start
//   zero             out  1      result == 0, held alongside result
module lu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_select_op,
  output logic             lu_select_group,
  input  logic             lu_s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  // The count reaching WIDTH-1 means this edge captures the final bit.
  assign last_bit = (cnt == LAST_CNT);

  // Opcode selects come straight from the latch, so they keep the last
  // accepted op even while idle.
  assign lu_select_group = op_q[1];
  assign lu_select_op    = op_q[0];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    lu_a      = 1'b0;
    lu_b      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        lu_a = a_sh[0];
        lu_b = b_sh[0];
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= 2'b00;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            op_q   <= op;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
          end
        end
        S_RUN: begin
          // Bits arrive LSB first, so shifting in from the top leaves
          // bit 0 of the operands at result[0] after WIDTH samples.
          result <= {lu_s, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          zero <= (result == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lu_serial_ctrl.sv
module tb_lu_serial_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             lu_a;
  logic             lu_b;
  logic             lu_select_op;
  logic             lu_select_group;
  logic             lu_s;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .op              (op),
    .a_in            (a_in),
    .b_in            (b_in),
    .lu_a            (lu_a),
    .lu_b            (lu_b),
    .lu_select_op    (lu_select_op),
    .lu_select_group (lu_select_group),
    .lu_s            (lu_s),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .zero            (zero)
  );

  // The external 1-bit logic unit.
  always_comb begin
    case ({lu_select_group, lu_select_op})
      2'b00:   lu_s = ~(lu_a & lu_b);
      2'b01:   lu_s = lu_a & lu_b;
      2'b10:   lu_s = ~(lu_a | lu_b);
      default: lu_s = lu_a | lu_b;
    endcase
  end

  // Whole-word reference for a serial run.
  function automatic logic [WIDTH-1:0] lu_ref(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] o);
    case (o)
      2'b00:   return ~(a & b);
      2'b01:   return a & b;
      2'b10:   return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  // Timeline model: mon_pos = -1 idle, 0..WIDTH-1 bit being streamed,
  // WIDTH = completion cycle.
  int               mon_pos = -1;
  bit               mon_en = 1'b0;
  logic [WIDTH-1:0] mon_a = '0;
  logic [WIDTH-1:0] mon_b = '0;
  logic [1:0]       mon_op = 2'b00;
  logic [WIDTH-1:0] mon_result = '0;
  logic             mon_zero = 1'b0;
  logic             prev_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mon_en     = 1'b1;
      mon_pos    = -1;
      mon_result = '0;
      mon_zero   = 1'b0;
      mon_op     = 2'b00;
    end else if (mon_en) begin
      if (mon_pos < 0) begin
        if (start) begin
          mon_a      = a_in;
          mon_b      = b_in;
          mon_op     = op;
          mon_pos    = 0;
          mon_result = '0;
          mon_zero   = 1'b0;
        end
      end else if (mon_pos == WIDTH - 1) begin
        mon_result = lu_ref(mon_a, mon_b, mon_op);
        mon_pos    = WIDTH;
      end else if (mon_pos == WIDTH) begin
        mon_zero = (mon_result == '0);
        mon_pos  = -1;
      end else begin
        mon_pos++;
      end
    end
  end

  always @(negedge clk) begin
    logic       exp_busy;
    logic       exp_done;
    logic       exp_la;
    logic       exp_lb;
    logic [2:0] idx;
    if (mon_en) begin
      idx      = mon_pos[2:0];
      exp_busy = (mon_pos >= 0) && (mon_pos < WIDTH);
      exp_done = (mon_pos == WIDTH);
      exp_la   = exp_busy ? mon_a[idx] : 1'b0;
      exp_lb   = exp_busy ? mon_b[idx] : 1'b0;
      total++;
      if (busy !== exp_busy) begin
        bad++; $display("FAIL mon_busy t=%0t got=%b want=%b", $time, busy, exp_busy);
      end
      total++;
      if (done !== exp_done) begin
        bad++; $display("FAIL mon_done t=%0t got=%b want=%b", $time, done, exp_done);
      end
      total++;
      if ({lu_a, lu_b} !== {exp_la, exp_lb}) begin
        bad++; $display("FAIL mon_lu_ab t=%0t got=%b%b want=%b%b", $time, lu_a, lu_b, exp_la, exp_lb);
      end
      total++;
      if ({lu_select_group, lu_select_op} !== mon_op) begin
        bad++; $display("FAIL mon_select t=%0t got=%b%b want=%b", $time, lu_select_group, lu_select_op, mon_op);
      end
      total++;
      if (zero !== mon_zero) begin
        bad++; $display("FAIL mon_zero t=%0t got=%b want=%b", $time, zero, mon_zero);
      end
      if (!exp_busy) begin
        total++;
        if (result !== mon_result) begin
          bad++; $display("FAIL mon_result t=%0t got=%h want=%h", $time, result, mon_result);
        end
      end
      total++;
      if (done === 1'b1 && prev_done === 1'b1) begin
        bad++; $display("FAIL mon_double_done t=%0t got=11 want=not 11", $time);
      end
      prev_done = done;
    end
  end

  // One single-cycle start, then follow the run to its done pulse
  // (bounded). Inputs are scrambled right after acceptance.
  task automatic do_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] o,
                        output int busy_cnt, output int first_busy, output int last_busy,
                        output int done_cyc, output logic [WIDTH-1:0] res,
                        output logic z, output int sel_bad);
    busy_cnt = 0; first_busy = 0; last_busy = 0; done_cyc = 0;
    res = '0; z = 1'b0; sel_bad = 0;
    @(posedge clk); #1;
    a_in = a; b_in = b; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = WIDTH'($urandom);
    b_in = WIDTH'($urandom);
    op   = 2'($urandom);
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      #1;
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = c;
        last_busy = c;
        if ({lu_select_group, lu_select_op} !== o) sel_bad++;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        res = result;
      end
      @(posedge clk); #1;
    end
    #1;
    z = zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    total++;
    if ({busy, done, zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000", busy, done, zero);
    end
    total++;
    if (result !== '0) begin
      bad++; $display("FAIL reset_result got=%h want=00", result);
    end
    total++;
    if ({lu_a, lu_b, lu_select_op, lu_select_group} !== 4'b0000) begin
      bad++; $display("FAIL reset_lu got=%b%b%b%b want=0000", lu_a, lu_b, lu_select_op, lu_select_group);
    end
  endtask

  task automatic test_basic();
    int bc, fb, lb, dc, sb;
    logic [WIDTH-1:0] r;
    logic z;
    do_txn(8'hF0, 8'hCC, 2'b01, bc, fb, lb, dc, r, z, sb);
    total++;
    if (bc != WIDTH || fb != 1 || lb != WIDTH) begin
      bad++; $display("FAIL basic_busy got=cnt%0d first%0d last%0d want=cnt8 first1 last8", bc, fb, lb);
    end
    total++;
    if (dc != WIDTH + 1) begin
      bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", dc, WIDTH + 1);
    end
    total++;
    if (r !== 8'hC0) begin
      bad++; $display("FAIL basic_result got=%h want=c0", r);
    end
    total++;
    if (z !== 1'b0) begin
      bad++; $display("FAIL basic_zero got=%b want=0", z);
    end
    total++;
    if (result !== 8'hC0) begin
      bad++; $display("FAIL basic_result_held got=%h want=c0", result);
    end
  endtask

  task automatic test_ops();
    logic [1:0]       ops  [3] = '{2'b11, 2'b00, 2'b10};
    logic [WIDTH-1:0] exps [3] = '{8'hFC, 8'h3F, 8'h03};
    int bc, fb, lb, dc, sb;
    logic [WIDTH-1:0] r;
    logic z;
    for (int i = 0; i < 3; i++) begin
      do_txn(8'hF0, 8'hCC, ops[i], bc, fb, lb, dc, r, z, sb);
      total++;
      if (r !== exps[i]) begin
        bad++; $display("FAIL ops_result op=%b got=%h want=%h", ops[i], r, exps[i]);
      end
      total++;
      if (sb != 0 || bc != WIDTH) begin
        bad++; $display("FAIL ops_select op=%b got=selbad%0d busy%0d want=selbad0 busy8", ops[i], sb, bc);
      end
    end
  endtask

  task automatic test_zero();
    int bc, fb, lb, dc, sb;
    logic [WIDTH-1:0] r;
    logic z;
    do_txn(8'h0F, 8'hF0, 2'b01, bc, fb, lb, dc, r, z, sb);
    total++;
    if (r !== 8'h00 || z !== 1'b1) begin
      bad++; $display("FAIL zero_and got=%h/%b want=00/1", r, z);
    end
    do_txn(8'hFF, 8'hFF, 2'b10, bc, fb, lb, dc, r, z, sb);
    total++;
    if (r !== 8'h00 || z !== 1'b1) begin
      bad++; $display("FAIL zero_nor got=%h/%b want=00/1", r, z);
    end
  endtask

  task automatic test_random();
    int bc, fb, lb, dc, sb;
    logic [WIDTH-1:0] r, a, b, e;
    logic [1:0] o;
    logic z;
    for (int i = 0; i < 16; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      o = 2'($urandom);
      e = lu_ref(a, b, o);
      do_txn(a, b, o, bc, fb, lb, dc, r, z, sb);
      total++;
      if (r !== e || dc != WIDTH + 1) begin
        bad++; $display("FAIL rand_result a=%h b=%h op=%b got=%h@%0d want=%h@9", a, b, o, r, dc, e);
      end
      total++;
      if (z !== (e == '0)) begin
        bad++; $display("FAIL rand_zero got=%b want=%b", z, (e == '0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int rises[$];
    int dones = 0;
    logic prev_b = 1'b0;
    @(posedge clk); #1;
    a_in = 8'hAA; b_in = 8'h55; op = 2'b11; start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #2;
      if (busy === 1'b1 && prev_b === 1'b0) rises.push_back(c);
      if (done === 1'b1) begin
        dones++;
        total++;
        if (result !== 8'hFF) begin
          bad++; $display("FAIL b2b_result cycle=%0d got=%h want=ff", c, result);
        end
      end
      prev_b = busy;
      a_in = (busy === 1'b1) ? WIDTH'($urandom) : 8'hAA;
    end
    start = 1'b0;
    total++;
    if (rises.size() != 4 || dones != 3) begin
      bad++; $display("FAIL b2b_count got=starts%0d dones%0d want=starts4 dones3", rises.size(), dones);
    end else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (rises[i] - rises[i-1] != WIDTH + 2) begin
          bad++; $display("FAIL b2b_spacing got=%0d want=%0d", rises[i] - rises[i-1], WIDTH + 2);
        end
      end
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    int bc, fb, lb, dc, sb;
    int late_done = 0;
    logic [WIDTH-1:0] r;
    logic z;
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'hFF; op = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_running got=%b want=1", busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    total++;
    if ({busy, done} !== 2'b00 || result !== '0) begin
      bad++; $display("FAIL rstmid_cleared got=busy%b done%b res%h want=busy0 done0 res00", busy, done, result);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      if (done === 1'b1) late_done++;
    end
    total++;
    if (late_done != 0) begin
      bad++; $display("FAIL rstmid_no_done got=%0d want=0", late_done);
    end
    do_txn(8'h3C, 8'h5A, 2'b00, bc, fb, lb, dc, r, z, sb);
    total++;
    if (r !== 8'hE7 || dc != WIDTH + 1) begin
      bad++; $display("FAIL rstmid_fresh got=%h@%0d want=e7@9", r, dc);
    end
  endtask

  task automatic test_reset_vs_start();
    int seen = 0;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; a_in = 8'h77; b_in = 8'h11; op = 2'b01;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (busy === 1'b1 || done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_vs_start got=%0d active cycles want=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_zero();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_vs_start();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
